// File: rtl/if_fetch_unit.sv
// Instruction fetch stage feeding the IF/ID register: one outstanding imem request, registered {pc, instr, valid}.
// Response-to-output takes one cycle. Under stall a late response parks in a one-entry skid, and a redirect flushes everything.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_from_if,
    output logic [31:0] instruction_from_if,
    output logic        if_valid_o
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DROP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_out_pc;
    logic [31:0] r_out_instr;
    logic        r_out_vld;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_instr;
    logic        r_skid_vld;

    logic        w_can_load;
    logic        w_rsp;
    logic        w_load_rsp;
    logic        w_to_skid;
    logic        w_load_skid;
    logic [31:0] w_redir_pc;

    assign w_can_load = !r_out_vld || !stall_i;
    assign w_rsp      = (r_state == ST_WAIT) && imem_rvalid_i;
    assign w_redir_pc = redirect_pc_i & ~32'h0000_0003;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ISSUE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; redirect wins over stall and response
    always_comb begin
        w_state_nxt = r_state;
        if (redirect_i) begin
            case (r_state)
                ST_ISSUE: w_state_nxt = ST_DROP;
                ST_WAIT:  w_state_nxt = imem_rvalid_i ? ST_ISSUE : ST_DROP;
                ST_DROP:  w_state_nxt = imem_rvalid_i ? ST_ISSUE : ST_DROP;
                ST_HOLD:  w_state_nxt = ST_ISSUE;
                default:  w_state_nxt = ST_ISSUE;
            endcase
        end else begin
            case (r_state)
                ST_ISSUE: w_state_nxt = ST_WAIT;
                ST_WAIT: begin
                    if (imem_rvalid_i) begin
                        w_state_nxt = w_can_load ? ST_ISSUE : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) begin
                        w_state_nxt = ST_ISSUE;
                    end
                end
                ST_DROP: begin
                    if (imem_rvalid_i) begin
                        w_state_nxt = ST_ISSUE;
                    end
                end
                default: w_state_nxt = ST_ISSUE;
            endcase
        end
    end

    // Output / datapath-control decode
    always_comb begin
        imem_req_o  = (r_state == ST_ISSUE) && !rst;
        imem_addr_o = imem_req_o ? r_fetch_pc : 32'h0000_0000;
        w_load_rsp  = w_rsp && w_can_load && !redirect_i;
        w_to_skid   = w_rsp && !w_can_load && !redirect_i;
        w_load_skid = (r_state == ST_HOLD) && r_skid_vld && !stall_i && !redirect_i;
    end

    // Fetch PC, skid entry and the registered IF/ID-side output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc   <= RESET_PC;
            r_out_pc     <= 32'h0000_0000;
            r_out_instr  <= NOP_INSTR;
            r_out_vld    <= 1'b0;
            r_skid_pc    <= 32'h0000_0000;
            r_skid_instr <= NOP_INSTR;
            r_skid_vld   <= 1'b0;
        end else if (redirect_i) begin
            r_fetch_pc  <= w_redir_pc;
            r_out_pc    <= 32'h0000_0000;
            r_out_instr <= NOP_INSTR;
            r_out_vld   <= 1'b0;
            r_skid_vld  <= 1'b0;
        end else begin
            if (w_rsp) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_load_rsp) begin
                r_out_pc    <= r_fetch_pc;
                r_out_instr <= imem_rdata_i;
                r_out_vld   <= 1'b1;
            end else if (w_load_skid) begin
                r_out_pc    <= r_skid_pc;
                r_out_instr <= r_skid_instr;
                r_out_vld   <= 1'b1;
                r_skid_vld  <= 1'b0;
            end else if (!stall_i) begin
                r_out_pc    <= 32'h0000_0000;
                r_out_instr <= NOP_INSTR;
                r_out_vld   <= 1'b0;
            end
            if (w_to_skid) begin
                r_skid_pc    <= r_fetch_pc;
                r_skid_instr <= imem_rdata_i;
                r_skid_vld   <= 1'b1;
            end
        end
    end

    assign pc_from_if          = r_out_pc;
    assign instruction_from_if = r_out_instr;
    assign if_valid_o          = r_out_vld;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed timing scenarios plus a randomized run against a stream-level reference model.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_from_if;
    logic [31:0] instruction_from_if;
    logic        if_valid_o;

    logic        stall2 = 1'b0;
    logic        redir2 = 1'b0;
    logic [31:0] rpc2   = 32'h0;
    logic        req2;
    logic [31:0] addr2;
    logic        rvalid2;
    logic [31:0] rdata2;
    logic [31:0] pc2;
    logic [31:0] instr2;
    logic        vld2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .pc_from_if(pc_from_if),
        .instruction_from_if(instruction_from_if), .if_valid_o(if_valid_o)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .stall_i(stall2), .redirect_i(redir2),
        .redirect_pc_i(rpc2), .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2), .pc_from_if(pc2),
        .instruction_from_if(instr2), .if_valid_o(vld2)
    );

    // Instruction memory for the main DUT: word at addr is addr+0x100
    int          mem_lat = 1;
    bit          mem_rand = 1'b0;
    bit          mem_pending = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;

    initial begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        forever begin
            @(negedge clk);
            if (imem_req_o) begin
                checks++;
                if (mem_pending) begin
                    errors++;
                    $display("FAIL one_outstanding: req=1 addr=%h while a request is pending, required req=0 (t=%0t)", imem_addr_o, $time);
                end
                mem_pending = 1'b1;
                mem_addr    = imem_addr_o;
                mem_cnt     = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
            end
            @(posedge clk);
            #1;
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
            if (mem_pending) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_addr + 32'h100;
                    mem_pending   = 1'b0;
                end
            end
        end
    end

    // One-cycle memory for the wrap-around instance
    initial begin
        logic        r;
        logic [31:0] a;
        rvalid2 = 1'b0;
        rdata2  = 32'h0;
        forever begin
            @(negedge clk);
            r = req2;
            a = addr2;
            @(posedge clk);
            #1;
            rvalid2 = r;
            rdata2  = r ? a + 32'h100 : 32'hDEAD_BEEF;
        end
    end

    // Stream-level reference: consumed instructions and issued addresses each walk
    // upward by 4 from RESET_PC or the latest redirect target.
    logic [31:0] exp_next = 32'h0;
    logic [31:0] exp_req  = 32'h0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_pc = 32'h0;
    logic [31:0] prev_instr = 32'h0;
    int          consumed = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                checks++;
                if (imem_req_o !== 1'b0) begin
                    errors++;
                    $display("FAIL req_in_reset: req=%b, required 0", imem_req_o);
                end
                exp_next  = 32'h0;
                exp_req   = 32'h0;
                prev_hold = 1'b0;
            end else begin
                if (!if_valid_o) begin
                    checks++;
                    if (pc_from_if !== 32'h0 || instruction_from_if !== NOP) begin
                        errors++;
                        $display("FAIL idle_output: pc=%h instr=%h, required pc=0 instr=%h", pc_from_if, instruction_from_if, NOP);
                    end
                end
                if (prev_hold) begin
                    checks++;
                    if (if_valid_o !== 1'b1 || pc_from_if !== prev_pc || instruction_from_if !== prev_instr) begin
                        errors++;
                        $display("FAIL stall_stable: vld=%b pc=%h instr=%h, required vld=1 pc=%h instr=%h",
                                 if_valid_o, pc_from_if, instruction_from_if, prev_pc, prev_instr);
                    end
                end
                if (if_valid_o && !stall_i) begin
                    checks++;
                    if (pc_from_if !== exp_next || instruction_from_if !== exp_next + 32'h100) begin
                        errors++;
                        $display("FAIL stream_order: pc=%h instr=%h, required pc=%h instr=%h",
                                 pc_from_if, instruction_from_if, exp_next, exp_next + 32'h100);
                    end
                    exp_next = exp_next + 32'd4;
                    consumed++;
                end
                checks++;
                if (imem_req_o) begin
                    if (imem_addr_o !== exp_req) begin
                        errors++;
                        $display("FAIL req_addr: addr=%h, required %h", imem_addr_o, exp_req);
                    end
                    exp_req = exp_req + 32'd4;
                end else if (imem_addr_o !== 32'h0) begin
                    errors++;
                    $display("FAIL idle_addr: addr=%h, required 0", imem_addr_o);
                end
                if (redirect_i) begin
                    exp_next = redirect_pc_i & ~32'h3;
                    exp_req  = redirect_pc_i & ~32'h3;
                end
                prev_hold  = if_valid_o && stall_i && !redirect_i;
                prev_pc    = pc_from_if;
                prev_instr = instruction_from_if;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0;
        mem_rand = 1'b0;
        @(negedge clk);
        mem_pending = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (if_valid_o !== 1'b0 || pc_from_if !== 32'h0 || instruction_from_if !== NOP || imem_req_o !== 1'b0 || imem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: vld=%b pc=%h instr=%h req=%b addr=%h, required 0/0/%h/0/0",
                     if_valid_o, pc_from_if, instruction_from_if, imem_req_o, imem_addr_o, NOP);
        end
        checks++;
        if (vld2 !== 1'b0 || pc2 !== 32'h0 || instr2 !== NOP) begin
            errors++;
            $display("FAIL reset_values_wrap: vld=%b pc=%h instr=%h, required 0/0/%h", vld2, pc2, instr2, NOP);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_req: req=%b addr=%h, required 1/00000000", imem_req_o, imem_addr_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sequential();
        logic        ev, er;
        logic [31:0] ep, ei, ea;
        mem_lat = 1;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            ev = (c >= 2) && (c % 2 == 0);
            ep = ev ? 32'((c / 2 - 1) * 4) : 32'h0;
            ei = ev ? ep + 32'h100 : NOP;
            er = (c % 2 == 0);
            ea = er ? 32'((c / 2) * 4) : 32'h0;
            checks++;
            if (if_valid_o !== ev || pc_from_if !== ep || instruction_from_if !== ei || imem_req_o !== er || imem_addr_o !== ea) begin
                errors++;
                $display("FAIL seq_cycle%0d: vld=%b pc=%h instr=%h req=%b addr=%h, required %b/%h/%h/%b/%h",
                         c, if_valid_o, pc_from_if, instruction_from_if, imem_req_o, imem_addr_o, ev, ep, ei, er, ea);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        mem_lat = 1;
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            stall_i = (c >= 4 && c <= 8);
            @(negedge clk);
            if (c >= 4 && c <= 9) begin
                checks++;
                if (if_valid_o !== 1'b1 || pc_from_if !== 32'h4 || instruction_from_if !== 32'h104) begin
                    errors++;
                    $display("FAIL stall_frozen_c%0d: vld=%b pc=%h instr=%h, required 1/00000004/00000104",
                             c, if_valid_o, pc_from_if, instruction_from_if);
                end
            end
            if (c >= 5 && c <= 9) begin
                checks++;
                if (imem_req_o !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_no_req_c%0d: req=%b, required 0", c, imem_req_o);
                end
            end
            if (c == 10) begin
                checks++;
                if (if_valid_o !== 1'b1 || pc_from_if !== 32'h8 || instruction_from_if !== 32'h108 || imem_req_o !== 1'b1 || imem_addr_o !== 32'hC) begin
                    errors++;
                    $display("FAIL stall_release: vld=%b pc=%h instr=%h req=%b addr=%h, required 1/00000008/00000108/1/0000000c",
                             if_valid_o, pc_from_if, instruction_from_if, imem_req_o, imem_addr_o);
                end
            end
            @(posedge clk); #1;
        end
        stall_i = 1'b0;
    endtask

    task automatic test_redirect_wait();
        mem_lat = 3;
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            redirect_i    = (c == 1);
            redirect_pc_i = (c == 1) ? 32'h203 : 32'h0;
            @(negedge clk);
            if (c >= 2 && c <= 7) begin
                checks++;
                if (if_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_wait_bubble_c%0d: vld=%b pc=%h, required vld=0", c, if_valid_o, pc_from_if);
                end
            end
            if (c == 2 || c == 3) begin
                checks++;
                if (imem_req_o !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_wait_drop_c%0d: req=%b, required 0", c, imem_req_o);
                end
            end
            if (c == 4) begin
                checks++;
                if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
                    errors++;
                    $display("FAIL redir_wait_req: req=%b addr=%h, required 1/00000200", imem_req_o, imem_addr_o);
                end
            end
            if (c == 8) begin
                checks++;
                if (if_valid_o !== 1'b1 || pc_from_if !== 32'h200 || instruction_from_if !== 32'h300) begin
                    errors++;
                    $display("FAIL redir_wait_out: vld=%b pc=%h instr=%h, required 1/00000200/00000300",
                             if_valid_o, pc_from_if, instruction_from_if);
                end
            end
            @(posedge clk); #1;
        end
        redirect_i = 1'b0;
    endtask

    task automatic test_redirect_hold();
        mem_lat = 1;
        do_reset();
        for (int c = 0; c <= 11; c++) begin
            stall_i       = (c >= 4 && c <= 9);
            redirect_i    = (c == 6);
            redirect_pc_i = (c == 6) ? 32'h400 : 32'h0;
            @(negedge clk);
            if (c == 7) begin
                checks++;
                if (if_valid_o !== 1'b0 || pc_from_if !== 32'h0 || instruction_from_if !== NOP || imem_req_o !== 1'b1 || imem_addr_o !== 32'h400) begin
                    errors++;
                    $display("FAIL redir_hold_flush: vld=%b pc=%h instr=%h req=%b addr=%h, required 0/0/%h/1/00000400",
                             if_valid_o, pc_from_if, instruction_from_if, imem_req_o, imem_addr_o, NOP);
                end
            end
            if (c == 9) begin
                checks++;
                if (if_valid_o !== 1'b1 || pc_from_if !== 32'h400 || instruction_from_if !== 32'h500) begin
                    errors++;
                    $display("FAIL redir_hold_target: vld=%b pc=%h instr=%h, required 1/00000400/00000500",
                             if_valid_o, pc_from_if, instruction_from_if);
                end
            end
            if (c == 11) begin
                checks++;
                if (if_valid_o !== 1'b1 || pc_from_if !== 32'h404 || instruction_from_if !== 32'h504) begin
                    errors++;
                    $display("FAIL redir_hold_next: vld=%b pc=%h instr=%h, required 1/00000404/00000504",
                             if_valid_o, pc_from_if, instruction_from_if);
                end
            end
            @(posedge clk); #1;
        end
        stall_i = 1'b0;
        redirect_i = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (vld2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC || instr2 !== 32'h0000_00FC || req2 !== 1'b1 || addr2 !== 32'h0) begin
                    errors++;
                    $display("FAIL wrap_first: vld=%b pc=%h instr=%h req=%b addr=%h, required 1/fffffffc/000000fc/1/00000000",
                             vld2, pc2, instr2, req2, addr2);
                end
            end
            if (c == 4) begin
                checks++;
                if (vld2 !== 1'b1 || pc2 !== 32'h0 || instr2 !== 32'h100) begin
                    errors++;
                    $display("FAIL wrap_second: vld=%b pc=%h instr=%h, required 1/00000000/00000100", vld2, pc2, instr2);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_in_wait();
        mem_lat = 2;
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            rst = (c == 1);
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || if_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_wait_req: req=%b addr=%h vld=%b, required 1/00000000/0", imem_req_o, imem_addr_o, if_valid_o);
                end
            end
            if (c == 3 || c == 4) begin
                checks++;
                if (if_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_wait_spurious_c%0d: vld=%b pc=%h, required vld=0", c, if_valid_o, pc_from_if);
                end
            end
            if (c == 5) begin
                checks++;
                if (if_valid_o !== 1'b1 || pc_from_if !== 32'h0 || instruction_from_if !== 32'h100) begin
                    errors++;
                    $display("FAIL rst_wait_out: vld=%b pc=%h instr=%h, required 1/00000000/00000100",
                             if_valid_o, pc_from_if, instruction_from_if);
                end
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        int start;
        do_reset();
        mem_rand = 1'b1;
        start = consumed;
        for (int c = 0; c < 3000; c++) begin
            stall_i       = ($urandom_range(0, 99) < 35);
            redirect_i    = ($urandom_range(0, 99) < 4);
            redirect_pc_i = $urandom;
            @(posedge clk); #1;
        end
        stall_i = 1'b0;
        redirect_i = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        checks++;
        if (consumed - start < 100) begin
            errors++;
            $display("FAIL random_progress: consumed=%0d instructions, required at least 100", consumed - start);
        end
        mem_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
